// File: rtl/sfq_arith_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sfq_arith_pkg
// Description : Shared state encoding, default width and borrow/overflow
//               helpers for the serial arithmetic blocks and their checkers.
// Revision    : 1.0 - initial release
// ============================================================================
package sfq_arith_pkg;

  localparam int c_default_width = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic sub_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic sub_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  // Overflow only when operand signs differ and the result sign departs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_nbit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_nbit_if
// Description : Operand/result handshake bundle for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_nbit_if
  import sfq_arith_pkg::*;
#(
  parameter int WIDTH = c_default_width
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, busy
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/full_subtractor_1bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : full_subtractor_1bit
// Description : Combinational one-bit full subtractor cell (d, bout).
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor_1bit
  import sfq_arith_pkg::*;
(
  input  wire logic a,
  input  wire logic b,
  input  wire logic bin,
  output logic      d,
  output logic      bout
);
  assign d    = sub_diff(a, b, bin);
  assign bout = sub_borrow(a, b, bin);
endmodule
`default_nettype wire

// File: rtl/serial_subtractor_nbit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_nbit
// Description : Bit-serial a - b - bin, LSB first, one cell evaluation per clk.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_nbit
  import sfq_arith_pkg::*;
#(
  parameter int WIDTH = c_default_width
)(
  input  wire logic clk,
  input  wire logic rst,
  serial_subtractor_nbit_if.slave bus
);
  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_sh_a;
  logic [WIDTH-1:0]   r_sh_b;
  logic [WIDTH-2:0]   r_dsh;
  logic [WIDTH-1:0]   w_dsh_next;
  logic [WIDTH-1:0]   r_diff;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_borrow;
  logic               r_bout;
  logic               r_ovf;
  logic               r_a_msb;
  logic               r_b_msb;
  logic               w_d;
  logic               w_bo;
  logic               w_last;
  logic               w_accept;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;

  full_subtractor_1bit u_cell (
    .a    (r_sh_a[0]),
    .b    (r_sh_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_last     = (r_cnt == c_last);
  assign w_accept   = w_in_ready & bus.in_valid;
  assign w_dsh_next = {w_d, r_dsh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Visible results only move on the final RUN edge; the shift reg is scratch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_dsh    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
    end else if (w_accept) begin
      r_sh_a   <= bus.a;
      r_sh_b   <= bus.b;
      r_borrow <= bus.bin;
      r_a_msb  <= bus.a[WIDTH-1];
      r_b_msb  <= bus.b[WIDTH-1];
      r_cnt    <= '0;
      r_dsh    <= '0;
    end else if (r_state == RUN) begin
      r_sh_a   <= {1'b0, r_sh_a[WIDTH-1:1]};
      r_sh_b   <= {1'b0, r_sh_b[WIDTH-1:1]};
      r_dsh    <= w_dsh_next[WIDTH-1:1];
      r_borrow <= w_bo;
      if (w_last) begin
        r_diff <= w_dsh_next;
        r_bout <= w_bo;
        r_ovf  <= sub_ovf(r_a_msb, r_b_msb, w_d);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_nbit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor_nbit
// Description : Directed self-checking bench for serial_subtractor_nbit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_nbit;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_subtractor_nbit_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor_nbit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept edge is cycle 0; result must appear after the 4th following edge.
  task automatic run_word(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic bin, input logic rdy, input logic [3:0] ed,
                          input logic eb, input logic eo);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.bin       = bin;
    bus.out_ready = rdy;
    check({tag, ".in_ready_idle"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, ".busy_run"}, bus.busy, 1);
    check({tag, ".in_ready_run"}, bus.in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.out_valid_c%0d", tag, k + 1), bus.out_valid, 0);
      @(negedge clk);
    end
    check({tag, ".out_valid"}, bus.out_valid, 1);
    check({tag, ".diff"}, bus.diff, ed);
    check({tag, ".bout"}, bus.bout, eb);
    check({tag, ".ovf"}, bus.ovf, eo);
    if (rdy) begin
      @(negedge clk);
      check({tag, ".out_valid_pulse"}, bus.out_valid, 0);
      check({tag, ".in_ready_back"}, bus.in_ready, 1);
      check({tag, ".diff_held"}, bus.diff, ed);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.diff", bus.diff, 0);
    check("rst.bout", bus.bout, 0);
    check("rst.ovf", bus.ovf, 0);
    rst = 1'b0;

    // 9-3: signed -7-3 leaves the 4-bit range, so ovf is set.
    run_word("w9m3", 4'h9, 4'h3, 1'b0, 1'b1, 4'h6, 1'b0, 1'b1);
    run_word("w0m0b", 4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0);

    // Backpressure: hold DONE while new operands are offered.
    run_word("bp", 4'h9, 4'h3, 1'b0, 1'b0, 4'h6, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = 4'h3;
      bus.b        = 4'h5;
      @(negedge clk);
      check($sformatf("bp.out_valid_%0d", k), bus.out_valid, 1);
      check($sformatf("bp.in_ready_%0d", k), bus.in_ready, 0);
      check($sformatf("bp.diff_%0d", k), bus.diff, 4'h6);
      check($sformatf("bp.ovf_%0d", k), bus.ovf, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp.release_in_ready", bus.in_ready, 1);
    check("bp.release_busy", bus.busy, 0);
    check("bp.release_diff", bus.diff, 4'h6);
    run_word("w3m5", 4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b1, 1'b0);

    // Reset during RUN cycle 2 aborts the word and clears outputs at once.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 4'h8;
    bus.b        = 4'h1;
    bus.bin      = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst.in_ready", bus.in_ready, 1);
    check("arst.out_valid", bus.out_valid, 0);
    check("arst.busy", bus.busy, 0);
    check("arst.diff", bus.diff, 0);
    check("arst.bout", bus.bout, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("arst.no_pulse_%0d", k), bus.out_valid, 0);
    end

    run_word("w8m1", 4'h8, 4'h1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1);
    run_word("w7mF", 4'h7, 4'hF, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
